accum_ctrl: RTL and testbench

Command sequencer for the 3-entry operand accumulator. Accepts one put/op command per fetched instruction from the decoder and enforces the accumulator's one-action-per-PC rule by stamping each command with a fresh tag. Drives the accumulator's `putEn`/`opEn`/`value`/`prog_ctr` pins and mirrors its occupancy, so the decoder can see full/empty without reading the accumulator's valid bits. Also flushes the accumulator after reset, because the accumulator has no reset of its own.

---
 rtl/accum_ctrl.sv | 112 +++++++++++
 tb/tb_accum_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/accum_ctrl.sv
// Command sequencer for the operand accumulator: tags each put/op with a
// fresh value, mirrors occupancy, and flushes the accumulator after reset.
module accum_ctrl #(
    parameter int DEPTH = 3,
    parameter int PC_W  = 12,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] prog_ctr,
    input  logic            put_req,
    input  logic            op_req,
    input  logic [7:0]      value_in,
    output logic            ready,
    output logic            putEn,
    output logic            opEn,
    output logic [7:0]      value,
    output logic [PC_W-1:0] acc_tag,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty,
    output logic            ovf_err,
    output logic            conflict_err
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE} state_t;

    state_t          state_q;
    logic            ready_q, put_en_q, op_en_q, ovf_q, conflict_q, last_pc_v_q;
    logic [7:0]      value_q;
    logic [PC_W-1:0] tag_q, last_pc_q;
    logic [CW-1:0]   count_q;
    logic            full_d, is_new_d, req_d;

    // A command is only acted on once per PC; repeats of the same PC are ignored.
    assign is_new_d = !last_pc_v_q || (prog_ctr != last_pc_q);
    assign req_d    = is_new_d && (put_req || op_req);
    assign full_d   = (count_q == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            ready_q     <= 1'b0;
            put_en_q    <= 1'b0;
            op_en_q     <= 1'b0;
            value_q     <= '0;
            tag_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            conflict_q  <= 1'b0;
            last_pc_q   <= '0;
            last_pc_v_q <= 1'b0;
        end else begin
            case (state_q)
                // The accumulator has no reset, so clear it with an op.
                S_INIT: begin
                    op_en_q  <= 1'b1;
                    put_en_q <= 1'b0;
                    tag_q    <= tag_q + 1'b1;
                    ready_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                S_IDLE: begin
                    put_en_q <= 1'b0;
                    op_en_q  <= 1'b0;
                    if (req_d) begin
                        last_pc_q   <= prog_ctr;
                        last_pc_v_q <= 1'b1;
                        if (put_req && op_req) begin
                            conflict_q <= 1'b1;
                        end else if (put_req && full_d) begin
                            ovf_q <= 1'b1;
                        end else if (put_req) begin
                            value_q  <= value_in;
                            put_en_q <= 1'b1;
                            tag_q    <= tag_q + 1'b1;
                            count_q  <= count_q + 1'b1;
                            ready_q  <= 1'b0;
                            state_q  <= S_ISSUE;
                        end else begin
                            op_en_q <= 1'b1;
                            tag_q   <= tag_q + 1'b1;
                            count_q <= '0;
                            ready_q <= 1'b0;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    put_en_q <= 1'b0;
                    op_en_q  <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign ready        = ready_q;
    assign putEn        = put_en_q;
    assign opEn         = op_en_q;
    assign value        = value_q;
    assign acc_tag      = tag_q;
    assign count        = count_q;
    assign full         = full_d;
    assign empty        = (count_q == '0);
    assign ovf_err      = ovf_q;
    assign conflict_err = conflict_q;
endmodule

// File: tb/tb_accum_ctrl.sv
// Scoreboard bench for accum_ctrl: expected enable pulses are queued as
// commands are driven and matched against the accumulator-side pins.
module tb_accum_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic [11:0] prog_ctr = '0;
    logic        put_req = 1'b0, op_req = 1'b0;
    logic [7:0]  value_in = '0;
    logic        ready, putEn, opEn, full, empty, ovf_err, conflict_err;
    logic [7:0]  value;
    logic [11:0] acc_tag;
    logic [1:0]  count;

    int n_chk = 0, n_fail = 0;

    // {putEn, opEn, value, acc_tag}
    logic [21:0] sb_q[$];

    logic [11:0] m_tag, m_lpc;
    logic [7:0]  m_val;
    int          m_cnt;
    logic        m_ovf, m_conf, m_lpv;

    accum_ctrl #(.DEPTH(3), .PC_W(12)) dut (
        .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .put_req(put_req),
        .op_req(op_req), .value_in(value_in), .ready(ready), .putEn(putEn),
        .opEn(opEn), .value(value), .acc_tag(acc_tag), .count(count),
        .full(full), .empty(empty), .ovf_err(ovf_err), .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (putEn === 1'b1 || opEn === 1'b1) begin
            if (sb_q.size() == 0)
                chk("unexpected_en", {10'd0, putEn, opEn, value, acc_tag}, 32'd0);
            else
                chk("issue", {10'd0, putEn, opEn, value, acc_tag}, {10'd0, sb_q.pop_front()});
        end
    end

    task automatic model(input logic [11:0] pc, input logic p, input logic o, input logic [7:0] v);
        if ((p || o) && (!m_lpv || pc != m_lpc)) begin
            m_lpv = 1'b1;
            m_lpc = pc;
            if (p && o) m_conf = 1'b1;
            else if (p && m_cnt == 3) m_ovf = 1'b1;
            else if (p) begin
                m_tag++; m_cnt++; m_val = v;
                sb_q.push_back({2'b10, v, m_tag});
            end else begin
                m_tag++; m_cnt = 0;
                sb_q.push_back({2'b01, m_val, m_tag});
            end
        end
    endtask

    task automatic wait_ready;
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    task automatic send(input logic [11:0] pc, input logic p, input logic o, input logic [7:0] v);
        wait_ready();
        prog_ctr = pc; put_req = p; op_req = o; value_in = v;
        model(pc, p, o, v);
        @(posedge clk); #1;
        put_req = 1'b0; op_req = 1'b0;
    endtask

    task automatic check_state(input string t);
        chk({t, "_count"}, {30'd0, count}, m_cnt);
        chk({t, "_full"},  {31'd0, full},  {31'd0, m_cnt == 3});
        chk({t, "_empty"}, {31'd0, empty}, {31'd0, m_cnt == 0});
        chk({t, "_ovf"},   {31'd0, ovf_err}, {31'd0, m_ovf});
        chk({t, "_conf"},  {31'd0, conflict_err}, {31'd0, m_conf});
    endtask

    task automatic do_reset;
        reset = 1'b1;
        m_tag = '0; m_lpc = '0; m_val = '0; m_cnt = 0;
        m_ovf = 1'b0; m_conf = 1'b0; m_lpv = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_en", {30'd0, putEn, opEn}, 32'd0);
        chk("rst_tag", {20'd0, acc_tag}, 32'd0);
        check_state("rst");
        reset = 1'b0;
        m_tag = 12'd1;
        sb_q.push_back({2'b01, 8'h00, 12'd1});
        @(posedge clk); #1;
        chk("flush_op", {31'd0, opEn}, 32'd1);
        chk("flush_tag", {20'd0, acc_tag}, 32'd1);
        @(posedge clk); #1;
        chk("post_flush_ready", {31'd0, ready}, 32'd1);
        check_state("post_flush");
    endtask

    initial begin
        do_reset();

        send(12'd10, 1'b1, 1'b0, 8'd5);
        send(12'd11, 1'b1, 1'b0, 8'd9);
        send(12'd12, 1'b1, 1'b0, 8'd13);
        check_state("fill");

        send(12'd13, 1'b1, 1'b0, 8'd7);
        chk("ovf_ready", {31'd0, ready}, 32'd1);
        check_state("ovf");
        send(12'd14, 1'b0, 1'b1, 8'd0);
        check_state("op");

        // Held request at one PC must issue only once.
        wait_ready();
        prog_ctr = 12'd20; put_req = 1'b1; value_in = 8'h20;
        model(12'd20, 1'b1, 1'b0, 8'h20);
        repeat (4) begin @(posedge clk); #1; end
        put_req = 1'b0;
        send(12'd21, 1'b1, 1'b0, 8'h21);
        check_state("hold");

        send(12'd30, 1'b1, 1'b1, 8'h30);
        check_state("conf");
        send(12'd30, 1'b1, 1'b1, 8'h31);
        send(12'd30, 1'b0, 1'b1, 8'h00);
        check_state("conf_repeat");

        for (int i = 0; m_tag != 12'hFFF; i++)
            send((i % 2 == 0) ? 12'd1000 : 12'd1001, 1'b0, 1'b1, 8'h00);
        send(12'd2000, 1'b1, 1'b0, 8'hAA);
        chk("wrap_tag", {20'd0, acc_tag}, {20'd0, m_tag});
        chk("wrap_put", {31'd0, putEn}, 32'd1);
        check_state("wrap");

        // Reset lands while the wrap put is in ISSUE.
        do_reset();
        send(12'd2000, 1'b1, 1'b0, 8'h55);
        check_state("after_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
